// File: rtl/mw_power_sequencer_if.sv
// Panel/timer-side signal bundle for the microwave cook-program sequencer.
// master = panel and countdown timer, slave = mw_power_sequencer.
interface mw_power_sequencer_if;
  logic        prog_wr;
  logic        prog_stage;
  logic [15:0] prog_time;
  logic [3:0]  prog_power;
  logic        startn;
  logic        stopn;
  logic        door_closed;
  logic        timer_zero;
  logic        timer_load;
  logic [15:0] timer_time;
  logic        timer_en;
  logic        mag_on;
  logic        stage_idx;
  logic        done;
  logic        beep;

  modport master (
    output prog_wr, prog_stage, prog_time, prog_power, startn, stopn, door_closed, timer_zero,
    input  timer_load, timer_time, timer_en, mag_on, stage_idx, done, beep
  );

  modport slave (
    input  prog_wr, prog_stage, prog_time, prog_power, startn, stopn, door_closed, timer_zero,
    output timer_load, timer_time, timer_en, mag_on, stage_idx, done, beep
  );
endinterface

// File: rtl/mw_power_sequencer.sv
// Two-stage cook-program sequencer: loads the countdown timer, gates it and duty-cycles the
// magnetron. Optional end-of-cook beeper enabled by defining MW_END_BEEP_EN.
module mw_power_sequencer #(
  parameter int unsigned TICKS_PER_SEC = 100,
`ifdef MW_END_BEEP_EN
  parameter int unsigned BEEP_TICKS    = 300,
`endif
  parameter int unsigned DUTY_WINDOW   = 10
) (
  input logic                 clk,
  input logic                 clear,
  mw_power_sequencer_if.slave bus
);

  localparam int unsigned SubW = $clog2(TICKS_PER_SEC);
  localparam int unsigned WinW = $clog2(DUTY_WINDOW);

  typedef enum logic [2:0] {StIdle, StLoad, StCook, StPause, StDone} state_e;

  state_e            state_q;
  logic              startn_q, stopn_q;
  logic [15:0]       time0_q, time1_q;
  logic [3:0]        pow0_q, pow1_q;
  logic [SubW-1:0]   sub_q, sub_d;
  logic [WinW-1:0]   win_q, win_d;
  logic              timer_load_q, timer_en_q, mag_on_q, stage_idx_q, done_q;
  logic [15:0]       timer_time_q;
  logic              start_press, stop_press, mag_d;
  logic [3:0]        pow_cur, pow_wr;

`ifdef MW_END_BEEP_EN
  localparam int unsigned BeepW = $clog2(BEEP_TICKS);
  logic              beep_q;
  logic [BeepW-1:0]  beep_cnt_q;
  assign bus.beep = beep_q;
`else
  assign bus.beep = 1'b0;
`endif

  always_comb begin
    start_press = startn_q & ~bus.startn;
    stop_press  = stopn_q & ~bus.stopn;
    pow_cur     = stage_idx_q ? pow1_q : pow0_q;
    pow_wr      = (bus.prog_power > 4'd10) ? 4'd10 : bus.prog_power;
    sub_d       = sub_q;
    win_d       = win_q;
    // Duty counters track the timer's own seconds: they move on every enabled cycle.
    if (state_q == StLoad) begin
      sub_d = '0;
      win_d = '0;
    end else if (timer_en_q) begin
      if (sub_q == SubW'(TICKS_PER_SEC - 1)) begin
        sub_d = '0;
        win_d = (win_q == WinW'(DUTY_WINDOW - 1)) ? '0 : win_q + 1'b1;
      end else begin
        sub_d = sub_q + 1'b1;
      end
    end
    mag_d = 32'(win_d) < 32'(pow_cur);
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q      <= StIdle;
      startn_q     <= 1'b1;
      stopn_q      <= 1'b1;
      time0_q      <= '0;
      time1_q      <= '0;
      pow0_q       <= '0;
      pow1_q       <= '0;
      sub_q        <= '0;
      win_q        <= '0;
      timer_load_q <= 1'b0;
      timer_time_q <= '0;
      timer_en_q   <= 1'b0;
      mag_on_q     <= 1'b0;
      stage_idx_q  <= 1'b0;
      done_q       <= 1'b0;
`ifdef MW_END_BEEP_EN
      beep_q       <= 1'b0;
      beep_cnt_q   <= '0;
`endif
    end else begin
      startn_q     <= bus.startn;
      stopn_q      <= bus.stopn;
      sub_q        <= sub_d;
      win_q        <= win_d;
      timer_load_q <= 1'b0;
      done_q       <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.prog_wr) begin
            if (bus.prog_stage) begin
              time1_q <= bus.prog_time;
              pow1_q  <= pow_wr;
            end else begin
              time0_q <= bus.prog_time;
              pow0_q  <= pow_wr;
            end
          end
          if (start_press && !stop_press && bus.door_closed && time0_q != '0) begin
            state_q      <= StLoad;
            stage_idx_q  <= 1'b0;
            timer_load_q <= 1'b1;
            timer_time_q <= time0_q;
          end
        end
        StLoad: begin
          state_q    <= StCook;
          timer_en_q <= 1'b1;
          mag_on_q   <= mag_d;
        end
        StCook: begin
          if (!bus.door_closed || stop_press) begin
            state_q    <= StPause;
            timer_en_q <= 1'b0;
            mag_on_q   <= 1'b0;
          end else if (bus.timer_zero) begin
            timer_en_q <= 1'b0;
            mag_on_q   <= 1'b0;
            if (!stage_idx_q && time1_q != '0) begin
              state_q      <= StLoad;
              stage_idx_q  <= 1'b1;
              timer_load_q <= 1'b1;
              timer_time_q <= time1_q;
            end else begin
              state_q <= StDone;
              done_q  <= 1'b1;
`ifdef MW_END_BEEP_EN
              beep_q     <= 1'b1;
              beep_cnt_q <= '0;
`endif
            end
          end else begin
            mag_on_q <= mag_d;
          end
        end
        StPause: begin
          if (stop_press) begin
            state_q     <= StIdle;
            stage_idx_q <= 1'b0;
          end else if (start_press && bus.door_closed) begin
            state_q    <= StCook;
            timer_en_q <= 1'b1;
            mag_on_q   <= mag_d;
          end
        end
        StDone: begin
`ifdef MW_END_BEEP_EN
          beep_cnt_q <= beep_cnt_q + 1'b1;
          if (start_press || stop_press || beep_cnt_q == BeepW'(BEEP_TICKS - 1)) begin
            state_q     <= StIdle;
            stage_idx_q <= 1'b0;
            beep_q      <= 1'b0;
          end
`else
          state_q     <= StIdle;
          stage_idx_q <= 1'b0;
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.timer_load = timer_load_q;
  assign bus.timer_time = timer_time_q;
  assign bus.timer_en   = timer_en_q;
  assign bus.mag_on     = mag_on_q;
  assign bus.stage_idx  = stage_idx_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_mw_power_sequencer.sv
// Directed + randomized bench for mw_power_sequencer with a behavioural BCD countdown timer
// and cook-program expectations computed from seconds, power and duty-window arithmetic.
module tb_mw_power_sequencer;
  logic clk = 1'b0;
  logic clear;
  always #5 clk = ~clk;

  mw_power_sequencer_if bus ();
  mw_power_sequencer dut (.clk(clk), .clear(clear), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;

  function automatic int bcd2sec(input logic [15:0] b);
    return (int'(b[15:12]) * 10 + int'(b[11:8])) * 60 + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [15:0] sec2bcd(input int s);
    int m = s / 60;
    int r = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(r / 10), 4'(r % 10)};
  endfunction

  // Countdown timer: decrements one second per 100 enabled clocks.
  logic [15:0] tm_time;
  int          tm_tick;
  always @(posedge clk) begin
    if (clear) begin
      tm_time <= '0;
      tm_tick <= 0;
    end else if (bus.timer_load) begin
      tm_time <= bus.timer_time;
      tm_tick <= 0;
    end else if (bus.timer_en && tm_time != 0) begin
      if (tm_tick == 99) begin
        tm_tick <= 0;
        tm_time <= sec2bcd(bcd2sec(tm_time) - 1);
      end else begin
        tm_tick <= tm_tick + 1;
      end
    end
  end
  assign bus.timer_zero = (tm_time == 16'h0000);

  // Activity monitor
  int          en_cnt, mag_cnt, load_cnt, done_cnt, beep_cnt, mag_bad;
  bit          saw_stage1;
  logic [15:0] last_time;
  bit          mag_hist [0:8191];
  always @(negedge clk) begin
    if (bus.timer_en) begin
      if (en_cnt < 8192) mag_hist[en_cnt] = bus.mag_on;
      en_cnt++;
      if (bus.mag_on) mag_cnt++;
    end
    if (bus.timer_load) begin
      load_cnt++;
      last_time = bus.timer_time;
    end
    if (bus.done) done_cnt++;
    if (bus.beep) beep_cnt++;
    if (bus.stage_idx) saw_stage1 = 1'b1;
    if (bus.mag_on && !bus.timer_en) mag_bad++;
  end

  task automatic clear_stats();
    en_cnt = 0; mag_cnt = 0; load_cnt = 0; done_cnt = 0; beep_cnt = 0; saw_stage1 = 1'b0;
    last_time = '0;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic prog(input bit stg, input int secs, input int pwr);
    bus.prog_wr    = 1'b1;
    bus.prog_stage = stg;
    bus.prog_time  = sec2bcd(secs);
    bus.prog_power = 4'(pwr);
    tick();
    bus.prog_wr    = 1'b0;
  endtask

  function automatic int clamp(input int p);
    return (p > 10) ? 10 : p;
  endfunction

  // Magnetron-on cycles for one stage: enabled cycle k lies in second k/100 of the stage.
  function automatic int exp_mag(input int t, input int p);
    int n = 0;
    if (t == 0) return 0;
    for (int k = 0; k <= 100 * t; k++) if ((k / 100) % 10 < clamp(p)) n++;
    return n;
  endfunction

  bit inject_wr = 1'b0;

  task automatic run_prog(input string tag, input int t0, input int p0, input int t1,
                          input int p1);
    int cyc = 0;
    int lat = (100 * t0 + 2) + ((t1 != 0) ? (100 * t1 + 2) : 0);
    int ens = (100 * t0 + 1) + ((t1 != 0) ? (100 * t1 + 1) : 0);
    prog(1'b0, t0, p0);
    prog(1'b1, t1, p1);
    clear_stats();
    bus.startn = 1'b0;
    while (cyc < lat + 50) begin
      tick();
      cyc++;
      if (cyc == 1) bus.startn = 1'b1;
      if (inject_wr && cyc == 60) begin
        bus.prog_wr = 1'b1; bus.prog_stage = 1'b1; bus.prog_time = 16'h0005;
      end
      if (inject_wr && cyc == 61) bus.prog_wr = 1'b0;
      if (done_cnt > 0) break;
    end
    check({tag, "_latency"}, cyc, lat + 1);
    check({tag, "_loads"}, load_cnt, (t1 != 0) ? 2 : 1);
    check({tag, "_last_time"}, int'(last_time), int'(sec2bcd((t1 != 0) ? t1 : t0)));
    check({tag, "_en_cycles"}, en_cnt, ens);
    check({tag, "_mag_cycles"}, mag_cnt, exp_mag(t0, p0) + exp_mag(t1, p1));
    check({tag, "_stage1"}, int'(saw_stage1), int'(t1 != 0));
    tick();
    check({tag, "_done_pulse"}, done_cnt, 1);
    check({tag, "_idle_outs"}, int'({bus.timer_en, bus.mag_on, bus.done}), 0);
`ifdef MW_END_BEEP_EN
    repeat (310) tick();
    check({tag, "_beep"}, beep_cnt, 300);
`else
    check({tag, "_beep"}, beep_cnt, 0);
`endif
  endtask

  initial begin
    int t0, t1, p0, p1;
    clear = 1'b1;
    bus.prog_wr = 1'b0; bus.prog_stage = 1'b0; bus.prog_time = '0; bus.prog_power = '0;
    bus.startn = 1'b1; bus.stopn = 1'b1; bus.door_closed = 1'b1;
    mag_bad = 0;
    clear_stats();
    repeat (3) tick();
    check("rst_load", int'(bus.timer_load), 0);
    check("rst_time", int'(bus.timer_time), 0);
    check("rst_en", int'(bus.timer_en), 0);
    check("rst_mag", int'(bus.mag_on), 0);
    check("rst_idx", int'(bus.stage_idx), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_beep", int'(bus.beep), 0);
    clear = 1'b0;
    tick();

    // Single stage full power; a mid-cook stage-1 write must be ignored.
    inject_wr = 1'b1;
    run_prog("t1", 12, 10, 0, 0);
    inject_wr = 1'b0;

    // Half power: on s0-4, off s5-9, on s10-14, off s15-19.
    run_prog("t2", 20, 5, 0, 0);
    for (int s = 0; s < 20; s++)
      check($sformatf("t2_mag_s%0d", s), int'(mag_hist[100 * s + 50]), int'((s % 10) < 5));

    run_prog("t3", 5, 10, 3, 3);
    run_prog("minute", 62, 3, 0, 0);

    // Door open mid-cook pauses; closing alone does not resume; start resumes.
    prog(1'b0, 30, 10);
    prog(1'b1, 0, 0);
    clear_stats();
    bus.startn = 1'b0; tick(); bus.startn = 1'b1;
    repeat (800) tick();
    bus.door_closed = 1'b0;
    tick();
    check("t4_door_en", int'(bus.timer_en), 0);
    check("t4_door_mag", int'(bus.mag_on), 0);
    repeat (200) tick();
    bus.door_closed = 1'b1;
    repeat (5) tick();
    check("t4_close_no_resume", int'(bus.timer_en), 0);
    bus.startn = 1'b0; tick(); bus.startn = 1'b1; tick();
    check("t4_resume_en", int'(bus.timer_en), 1);
    check("t4_resume_mag", int'(bus.mag_on), 1);
    for (int i = 0; i < 2500 && done_cnt == 0; i++) tick();
    check("t4_done", done_cnt, 1);
    check("t4_en_cycles", en_cnt, 3001);
    check("t4_mag_cycles", mag_cnt, 3001);
    check("t4_loads", load_cnt, 1);
`ifdef MW_END_BEEP_EN
    repeat (310) tick();
`endif

    // Stop pauses, second stop cancels without done.
    prog(1'b0, 20, 4);
    clear_stats();
    bus.startn = 1'b0; tick(); bus.startn = 1'b1;
    repeat (300) tick();
    bus.stopn = 1'b0; tick(); bus.stopn = 1'b1; tick();
    check("t5_stop_en", int'(bus.timer_en), 0);
    repeat (10) tick();
    bus.stopn = 1'b0; tick(); bus.stopn = 1'b1;
    repeat (20) tick();
    check("t5_cancel_done", done_cnt, 0);
    check("t5_cancel_en", int'(bus.timer_en), 0);
    // Restart from IDLE reloads; simultaneous start+stop in PAUSE cancels.
    bus.startn = 1'b0; tick(); bus.startn = 1'b1;
    repeat (50) tick();
    check("t5_restart_loads", load_cnt, 2);
    bus.stopn = 1'b0; tick(); bus.stopn = 1'b1; tick();
    bus.startn = 1'b0; bus.stopn = 1'b0; tick(); bus.startn = 1'b1; bus.stopn = 1'b1;
    repeat (5) tick();
    check("t5_both_en", int'(bus.timer_en), 0);
    bus.startn = 1'b0; tick(); bus.startn = 1'b1;
    repeat (5) tick();
    check("t5_both_to_idle", load_cnt, 3);
    check("t5_both_cooking", int'(bus.timer_en), 1);

    // Clear mid-cook returns everything to reset.
    clear = 1'b1; tick(); clear = 1'b0;
    check("t6_clear_outs", int'({bus.timer_load, bus.timer_en, bus.mag_on, bus.stage_idx,
                                 bus.done, bus.beep}), 0);
    repeat (20) tick();
    check("t6_clear_no_done", done_cnt, 0);

    // Zero stage-0 time and open door both block start.
    clear_stats();
    prog(1'b0, 0, 5);
    prog(1'b1, 3, 5);
    bus.startn = 1'b0; tick(); bus.startn = 1'b1;
    repeat (20) tick();
    check("t5_zero_start", load_cnt, 0);
    prog(1'b0, 5, 5);
    bus.door_closed = 1'b0;
    bus.startn = 1'b0; tick(); bus.startn = 1'b1;
    repeat (20) tick();
    check("door_open_start", load_cnt, 0);
    bus.door_closed = 1'b1;
    tick();

    for (int r = 0; r < 6; r++) begin
      t0 = int'($urandom_range(1, 15));
      t1 = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 10));
      p0 = int'($urandom_range(0, 15));
      p1 = int'($urandom_range(0, 15));
      run_prog($sformatf("rnd%0d", r), t0, p0, t1, p1);
    end

    check("mag_without_en", mag_bad, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
